rv32i_ifetch: RTL

RV32I_IFETCH -- requirements
Module: rv32i_ifetch

---
 rtl/rv32i_ifetch.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/rv32i_ifetch.sv
// rv32i_ifetch: instruction fetch unit with a registered prefetch FIFO.
// All addresses are word indices (sequential fetch is +1, silent 32-bit wrap).
//
// Ports
//   clk          single clock, rising edge
//   RN           synchronous active-high reset
//   imem_req     read request to instruction memory (held until ack)
//   imem_addr    word address of the live request
//   imem_ack     read complete, imem_rdata valid this cycle
//   imem_rdata   instruction word from memory
//   br_en        redirect from execute
//   br_target    redirect word address
//   id_ready     decode accepts the buffer head this cycle
//   if_valid     buffer head holds a valid instruction
//   if_ir        instruction at buffer head
//   if_npc       word address of that instruction + 1
module rv32i_ifetch #(
  parameter logic [31:0] RESET_PC  = 32'd0,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        RN,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        br_en,
  input  logic [31:0] br_target,
  input  logic        id_ready,
  output logic        if_valid,
  output logic [31:0] if_ir,
  output logic [31:0] if_npc
);

  localparam int unsigned PTR_W = $clog2(BUF_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(BUF_DEPTH);

  typedef enum logic [1:0] {IDLE, BUSY, FLUSH} state_t;

  state_t             r_state;
  logic               r_req;
  logic [31:0]        r_addr;
  logic [31:0]        r_fetch_pc;
  logic [31:0]        r_tgt;
  logic [31:0]        r_ir  [BUF_DEPTH];
  logic [31:0]        r_npc [BUF_DEPTH];
  logic [PTR_W-1:0]   r_wptr;
  logic [PTR_W-1:0]   r_rptr;
  logic [CNT_W-1:0]   r_count;

  logic               w_push;
  logic               w_pop;
  logic [31:0]        w_next_addr;

  assign w_next_addr = r_addr + 32'd1;
  // Only an unredirected ack in BUSY delivers data; FLUSH acks are dropped.
  assign w_push      = (r_state == BUSY) && imem_ack && !br_en;
  assign w_pop       = (r_count != '0) && id_ready;

  assign imem_req  = r_req;
  assign imem_addr = r_addr;
  assign if_valid  = (r_count != '0);
  assign if_ir     = r_ir[r_rptr];
  assign if_npc    = r_npc[r_rptr];

  // Fetch FSM. A request is only launched from IDLE and only with no outstanding
  // request, so the credit test reduces to count < depth.
  always_ff @(posedge clk) begin
    if (RN) begin
      r_state    <= IDLE;
      r_req      <= 1'b0;
      r_addr     <= '0;
      r_fetch_pc <= RESET_PC;
      r_tgt      <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (br_en) begin
            r_fetch_pc <= br_target;
          end else if (r_count < DEPTH_C) begin
            r_req   <= 1'b1;
            r_addr  <= r_fetch_pc;
            r_state <= BUSY;
          end
        end
        BUSY: begin
          if (imem_ack) begin
            r_req      <= 1'b0;
            r_state    <= IDLE;
            r_fetch_pc <= br_en ? br_target : w_next_addr;
          end else if (br_en) begin
            r_tgt   <= br_target;
            r_state <= FLUSH;
          end
        end
        FLUSH: begin
          if (imem_ack) begin
            r_req      <= 1'b0;
            r_state    <= IDLE;
            r_fetch_pc <= br_en ? br_target : r_tgt;
          end else if (br_en) begin
            r_tgt <= br_target;
          end
        end
        default: begin
          r_req   <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Prefetch FIFO; a redirect empties it ahead of any same-cycle push or pop.
  always_ff @(posedge clk) begin
    if (RN) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        r_ir[i]  <= '0;
        r_npc[i] <= '0;
      end
    end else if (br_en) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_ir[r_wptr]  <= imem_rdata;
        r_npc[r_wptr] <= w_next_addr;
        r_wptr        <= r_wptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
